// File: rtl/chess_clock_nplayer.sv
// rtl/chess_clock_nplayer.sv - N-player chess clock core; optional per-move bonus under CHESS_CLOCK_BONUS_EN
module chess_clock_nplayer #(
    parameter int N_PLAYERS  = 2,
    parameter int TIME_W     = 10,
    parameter int START_TIME = 10,
    parameter int INCREMENT  = 0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_tick,
    input  logic [N_PLAYERS-1:0]          i_press,
    input  logic                          i_pause,
    output logic [1:0]                    o_state,
    output logic [2:0]                    o_active,
    output logic [N_PLAYERS*TIME_W-1:0]   o_time,
    output logic [N_PLAYERS-1:0]          o_flag
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_RUN     = 2'b01;
    localparam logic [1:0] S_PAUSE   = 2'b10;
    localparam logic [1:0] S_TIMEOUT = 2'b11;

    localparam logic [TIME_W-1:0] START_V = TIME_W'(START_TIME);
    localparam logic [2:0]        LAST    = 3'(N_PLAYERS - 1);

    logic [1:0]              state;
    logic [2:0]              active;
    logic [N_PLAYERS-1:0]    flag;
    logic [TIME_W-1:0]       cnt [N_PLAYERS];
    logic [N_PLAYERS-1:0]    press_q;
    logic                    pause_q;

    logic [N_PLAYERS-1:0]    press_edge;
    logic                    pause_edge;
    logic                    act_pressed;
    logic [TIME_W-1:0]       cur;
    logic [TIME_W-1:0]       dec;
    logic [TIME_W-1:0]       after_tick;
    logic [TIME_W-1:0]       moved;
    logic                    timeout_hit;
    logic [2:0]              next_active;
    logic [2:0]              first_k;
    logic [2:0]              idle_active;
    logic [N_PLAYERS-1:0]    flag_next;

    // Edge detection, active-counter selection and the next counter value for the running player
    always_comb begin
        press_edge  = i_press & ~press_q;
        pause_edge  = i_pause & ~pause_q;
        cur         = '0;
        act_pressed = 1'b0;
        flag_next   = '0;
        first_k     = '0;
        for (int k = 0; k < N_PLAYERS; k++) begin
            if (3'(k) == active) begin
                cur          = cnt[k];
                act_pressed  = press_edge[k];
                flag_next[k] = 1'b1;
            end
        end
        // Descending scan so the lowest simultaneous presser wins
        for (int k = N_PLAYERS - 1; k >= 0; k--) begin
            if (press_edge[k]) first_k = 3'(k);
        end
        next_active = (active == LAST) ? 3'd0 : active + 3'd1;
        idle_active = (first_k == LAST) ? 3'd0 : first_k + 3'd1;
        dec         = (cur != '0) ? cur - 1'b1 : cur;
        after_tick  = i_tick ? dec : cur;
        timeout_hit = i_tick && (dec == '0);
    end

`ifdef CHESS_CLOCK_BONUS_EN
    logic [TIME_W:0] bonus_sum;
    // Saturating bonus applied to the mover's post-tick time
    always_comb begin
        bonus_sum = {1'b0, after_tick} + (TIME_W + 1)'(INCREMENT);
        moved     = bonus_sum[TIME_W] ? {TIME_W{1'b1}} : bonus_sum[TIME_W-1:0];
    end
`else
    // Without the bonus a press only hands the turn over
    always_comb begin
        moved = after_tick;
    end
`endif

    // Main state machine and counter updates
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state   <= S_IDLE;
            active  <= 3'd0;
            flag    <= '0;
            press_q <= '0;
            pause_q <= 1'b0;
            for (int k = 0; k < N_PLAYERS; k++) cnt[k] <= START_V;
        end else begin
            press_q <= i_press;
            pause_q <= i_pause;
            case (state)
                S_IDLE: begin
                    if (|press_edge) begin
                        state  <= S_RUN;
                        active <= idle_active;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < N_PLAYERS; k++) begin
                        if (3'(k) == active) begin
                            if (timeout_hit)      cnt[k] <= '0;
                            else if (pause_edge)  cnt[k] <= after_tick;
                            else if (act_pressed) cnt[k] <= moved;
                            else                  cnt[k] <= after_tick;
                        end
                    end
                    if (timeout_hit) begin
                        state <= S_TIMEOUT;
                        flag  <= flag_next;
                    end else if (pause_edge) begin
                        state <= S_PAUSE;
                    end else if (act_pressed) begin
                        active <= next_active;
                    end
                end
                S_PAUSE: begin
                    if (pause_edge) state <= S_RUN;
                end
                default: begin
                end
            endcase
        end
    end

    // Pack the per-player counters onto the output bus
    always_comb begin
        o_time = '0;
        for (int k = 0; k < N_PLAYERS; k++) o_time[k*TIME_W +: TIME_W] = cnt[k];
    end

    assign o_state  = state;
    assign o_active = active;
    assign o_flag   = flag;

endmodule

// File: tb/tb_chess_clock_nplayer.sv
// tb/tb_chess_clock_nplayer.sv - self-checking bench for chess_clock_nplayer
module tb_chess_clock_nplayer;

    localparam int N   = 3;
    localparam int TW  = 4;
    localparam int ST  = 10;
    localparam int INC = 3;
    localparam int MAXT = (1 << TW) - 1;

    logic            clk = 1'b0;
    logic            i_reset;
    logic            i_tick;
    logic [N-1:0]    i_press;
    logic            i_pause;
    logic [1:0]      o_state;
    logic [2:0]      o_active;
    logic [N*TW-1:0] o_time;
    logic [N-1:0]    o_flag;

    int total = 0;
    int bad   = 0;

    int       m_time [N];
    int       m_state;
    int       m_active;
    int       m_flag;
    logic [N-1:0] m_pp;
    logic     m_ppause;

    chess_clock_nplayer #(
        .N_PLAYERS(N), .TIME_W(TW), .START_TIME(ST), .INCREMENT(INC)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_press(i_press),
        .i_pause(i_pause), .o_state(o_state), .o_active(o_active),
        .o_time(o_time), .o_flag(o_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [N*TW-1:0] model_time();
        logic [N*TW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*TW +: TW] = TW'(m_time[k]);
        return v;
    endfunction

    function automatic int bonus(input int t);
`ifdef CHESS_CLOCK_BONUS_EN
        return (t + INC > MAXT) ? MAXT : t + INC;
`else
        return t;
`endif
    endfunction

    // Drive one cycle of inputs, advance the reference model, sample #1 after the edge
    task automatic step(input bit rst, input bit tick, input logic [N-1:0] press, input bit pause);
        logic [N-1:0] pe;
        bit pa;
        int t;
        int a;
        int first;
        i_reset = !rst;
        i_tick  = tick;
        i_press = press;
        i_pause = pause;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) m_time[k] = ST;
            m_state = 0; m_active = 0; m_flag = 0;
            m_pp = '0; m_ppause = 1'b0;
        end else begin
            pe = press & ~m_pp;
            pa = pause && !m_ppause;
            a  = m_active;
            case (m_state)
                0: if (pe != 0) begin
                    first = 0;
                    for (int k = N - 1; k >= 0; k--) if (pe[k]) first = k;
                    m_active = (first + 1) % N;
                    m_state  = 1;
                end
                1: begin
                    t = m_time[a];
                    if (tick && t > 0) t = t - 1;
                    if (tick && t == 0) begin
                        m_time[a] = 0; m_state = 3; m_flag = 1 << a;
                    end else if (pa) begin
                        m_time[a] = t; m_state = 2;
                    end else if (pe[a]) begin
                        m_time[a] = bonus(t); m_active = (a + 1) % N;
                    end else begin
                        m_time[a] = t;
                    end
                end
                2: if (pa) m_state = 1;
                default: ;
            endcase
            m_pp = press; m_ppause = pause;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, '0, 0);
        step(1, 1, 3'b111, 1);
        total++; if (o_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", o_state); end
        total++; if (o_active !== 3'd0) begin bad++; $display("FAIL reset_active got=%0d exp=0", o_active); end
        total++; if (o_flag !== 3'b000) begin bad++; $display("FAIL reset_flag got=%b exp=000", o_flag); end
        total++; if (o_time !== 12'hAAA) begin bad++; $display("FAIL reset_time got=%h exp=aaa", o_time); end
    endtask

    task automatic test_start_runout();
        logic [N*TW-1:0] snap;
        step(0, 0, '0, 0);
        step(0, 0, 3'b001, 0);
        total++; if (o_state !== 2'b01) begin bad++; $display("FAIL start_state got=%b exp=01", o_state); end
        total++; if (o_active !== 3'd1) begin bad++; $display("FAIL start_active got=%0d exp=1", o_active); end
        step(0, 0, '0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, '0, 0);
            total++;
            if (o_time[TW +: TW] !== TW'(10 - i)) begin
                bad++; $display("FAIL runout_time tick=%0d got=%0d exp=%0d", i, o_time[TW +: TW], 10 - i);
            end
        end
        total++; if (o_state !== 2'b11) begin bad++; $display("FAIL runout_state got=%b exp=11", o_state); end
        total++; if (o_flag !== 3'b010) begin bad++; $display("FAIL runout_flag got=%b exp=010", o_flag); end
        snap = 12'hA0A;
        step(0, 1, 3'b010, 1);
        step(0, 1, '0, 0);
        total++; if (o_time !== snap) begin bad++; $display("FAIL timeout_hold_time got=%h exp=%h", o_time, snap); end
        total++; if (o_active !== 3'd1 || o_flag !== 3'b010 || o_state !== 2'b11) begin
            bad++; $display("FAIL timeout_hold got=%0d/%b/%b exp=1/010/11", o_active, o_flag, o_state);
        end
    endtask

    task automatic test_rotation_pause();
        int exp_act [4] = '{0, 1, 2, 0};
        logic [N-1:0] who [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
        logic [N*TW-1:0] snap;
        step(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, who[i], 0);
            total++;
            if (o_active !== 3'(exp_act[i])) begin
                bad++; $display("FAIL rotate step=%0d got=%0d exp=%0d", i, o_active, exp_act[i]);
            end
            step(0, 0, '0, 0);
        end
        step(0, 1, '0, 0);
        step(0, 0, '0, 1);
        total++; if (o_state !== 2'b10) begin bad++; $display("FAIL pause_enter got=%b exp=10", o_state); end
        snap = model_time();
        for (int i = 0; i < 5; i++) step(0, 1, (i % 2 == 0) ? 3'b001 : 3'b000, 1);
        total++; if (o_time !== snap) begin bad++; $display("FAIL pause_freeze got=%h exp=%h", o_time, snap); end
        total++; if (o_active !== 3'd0) begin bad++; $display("FAIL pause_active got=%0d exp=0", o_active); end
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        total++; if (o_state !== 2'b01 || o_active !== 3'd0) begin
            bad++; $display("FAIL pause_resume got=%b/%0d exp=01/0", o_state, o_active);
        end
        step(0, 0, '0, 0);
    endtask

    task automatic test_bonus();
        logic [N*TW-1:0] exp_all;
        step(1, 0, '0, 0);
        step(0, 0, 3'b100, 0);
        step(0, 0, '0, 0);
        step(0, 0, 3'b001, 0);
`ifdef CHESS_CLOCK_BONUS_EN
        total++; if (o_time[0 +: TW] !== 4'd13) begin bad++; $display("FAIL bonus_first got=%0d exp=13", o_time[0 +: TW]); end
`else
        total++; if (o_time[0 +: TW] !== 4'd10) begin bad++; $display("FAIL bonus_first got=%0d exp=10", o_time[0 +: TW]); end
`endif
        total++; if (o_active !== 3'd1) begin bad++; $display("FAIL bonus_active got=%0d exp=1", o_active); end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, 0);
            step(0, 0, 3'(1 << ((i + 1) % N)), 0);
        end
`ifdef CHESS_CLOCK_BONUS_EN
        exp_all = 12'hFFF;
`else
        exp_all = 12'hAAA;
`endif
        total++; if (o_time !== exp_all) begin bad++; $display("FAIL bonus_saturate got=%h exp=%h", o_time, exp_all); end
        step(0, 0, '0, 0);
    endtask

    task automatic test_collision();
        step(1, 0, '0, 0);
        step(0, 0, 3'b001, 0);
        step(0, 0, '0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, '0, 0);
        total++; if (o_time[TW +: TW] !== 4'd1) begin bad++; $display("FAIL collide_pre got=%0d exp=1", o_time[TW +: TW]); end
        step(0, 1, 3'b010, 0);
        total++; if (o_time[TW +: TW] !== 4'd0 || o_state !== 2'b11) begin
            bad++; $display("FAIL collide_timeout got=%0d/%b exp=0/11", o_time[TW +: TW], o_state);
        end
        total++; if (o_active !== 3'd1 || o_flag !== 3'b010) begin
            bad++; $display("FAIL collide_active got=%0d/%b exp=1/010", o_active, o_flag);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 0, '0, 0);
        step(0, 0, 3'b001, 0);
        step(0, 0, '0, 0);
        step(0, 1, 3'b010, 1);
        total++; if (o_state !== 2'b10 || o_active !== 3'd1 || o_time[TW +: TW] !== 4'd9) begin
            bad++; $display("FAIL pause_vs_press got=%b/%0d/%0d exp=10/1/9", o_state, o_active, o_time[TW +: TW]);
        end
    endtask

    task automatic test_reset_midrun();
        step(1, 0, '0, 0);
        step(0, 0, 3'b010, 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0);
        step(1, 1, 3'b100, 0);
        total++; if (o_time !== 12'hAAA || o_state !== 2'b00) begin
            bad++; $display("FAIL midrun_reset got=%h/%b exp=aaa/00", o_time, o_state);
        end
        total++; if (o_active !== 3'd0 || o_flag !== 3'b000) begin
            bad++; $display("FAIL midrun_reset_act got=%0d/%b exp=0/000", o_active, o_flag);
        end
    endtask

    task automatic test_random();
        bit rst, tick, pause;
        logic [N-1:0] press;
        step(1, 0, '0, 0);
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom % 60) == 0;
            tick  = ($urandom % 3) == 0;
            pause = ($urandom % 12) == 0;
            press = 3'($urandom % 8) & 3'($urandom % 8);
            step(rst, tick, press, pause);
            total++;
            if (o_state !== 2'(m_state) || o_active !== 3'(m_active) ||
                o_flag !== 3'(m_flag) || o_time !== model_time()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b/%0d/%b/%h exp=%0d/%0d/%0d/%h", i,
                         o_state, o_active, o_flag, o_time, m_state, m_active, m_flag, model_time());
            end
        end
    endtask

    initial begin
        i_reset = 1'b0; i_tick = 1'b0; i_press = '0; i_pause = 1'b0;
        m_state = 0; m_active = 0; m_flag = 0; m_pp = '0; m_ppause = 1'b0;
        for (int k = 0; k < N; k++) m_time[k] = ST;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_start_runout();
        test_rotation_pause();
        test_bonus();
        test_collision();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
